// File: rtl/lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lstm_seq_ctrl
//   Drives one external lstm_cell over a sequence of seq_len timesteps.
//   X samples arrive on a valid/ready stream. The recurrent state (c, h) is
//   held in registers between steps and fed to the cell. After the cell has
//   had time to settle, its outputs are captured and h is emitted downstream.
//   Weights/biases live outside this block and must stay constant for a run.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   start, seq_len           begin a run of seq_len steps (sampled in IDLE)
//   c_init, h_init           initial recurrent state (sampled with start)
//   x_valid/x_ready/x_data   input sample stream
//   cell_x/c_in/h_in         registered cell inputs
//   cell_c_out/h_out         cell outputs (valid CELL_LAT cycles after inputs)
//   h_valid/h_ready/h_data   hidden-output stream, one beat per step
//   step_idx                 0-based index of the step in progress
//   busy, done               run active / one-cycle end-of-run pulse
// -----------------------------------------------------------------------------
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int LEN_W       = 8,
  parameter int CELL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      seq_len,
  input  logic [DATA_WIDTH-1:0] c_init,
  input  logic [DATA_WIDTH-1:0] h_init,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_ready,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c_in,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  h_valid,
  output logic [DATA_WIDTH-1:0] h_data,
  input  logic                  h_ready,
  output logic [LEN_W-1:0]      step_idx,
  output logic                  busy,
  output logic                  done
);

  // Values are fixed-point but only passed through; the format is never used.
  if (CELL_LAT < 1 || FRACT_WIDTH > DATA_WIDTH) begin : g_bad_params
    $error("lstm_seq_ctrl: CELL_LAT must be >= 1 and FRACT_WIDTH <= DATA_WIDTH");
  end

  localparam int                CNT_W    = $clog2(CELL_LAT + 1);
  // The cell output is first stable in the cycle after CELL_LAT edges past the
  // input change, so it is captured on edge CELL_LAT+1 after the X accept.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CELL_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_EMIT,
    S_FIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_step;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_cx;
  logic [DATA_WIDTH-1:0] r_cc;
  logic [DATA_WIDTH-1:0] r_ch;
  logic [DATA_WIDTH-1:0] r_cnext;
  logic [DATA_WIDTH-1:0] r_hdata;
  logic                  w_last;

  // Comparing against len-1 (len is never 0 here) keeps step_idx from ever
  // counting past seq_len-1, so a full-scale seq_len cannot wrap it.
  assign w_last = (r_step == (r_len - LEN_W'(1)));

  // NOTE: state and data registers use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    x_ready     = 1'b0;
    h_valid     = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = (seq_len == '0) ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        x_ready = 1'b1;
        if (x_valid) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == CNT_LAST) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        h_valid = 1'b1;
        if (h_ready) w_state_nxt = w_last ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every register here is cleared by reset because each one is
  // visible on a port or gates a visible value; there is no storage array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len   <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_cx    <= '0;
      r_cc    <= '0;
      r_ch    <= '0;
      r_cnext <= '0;
      r_hdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && seq_len != '0) begin
            r_len  <= seq_len;
            r_cc   <= c_init;
            r_ch   <= h_init;
            r_step <= '0;
          end
        end
        S_LOAD: begin
          if (x_valid) begin
            r_cx  <= x_data;
            r_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_cnext <= cell_c_out;
            r_hdata <= cell_h_out;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EMIT: begin
          // Cell inputs change only once h is accepted, so they stay stable
          // from the X accept through the whole EMIT wait.
          if (h_ready) begin
            r_cc <= r_cnext;
            r_ch <= r_hdata;
            if (!w_last) r_step <= r_step + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cell_x    = r_cx;
  assign cell_c_in = r_cc;
  assign cell_h_in = r_ch;
  assign h_data    = r_hdata;
  assign step_idx  = r_step;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lstm_seq_ctrl
//   Bench for lstm_seq_ctrl. A toy cell (c_out = c_in + x, h_out = c_out >> 1,
//   two-cycle delay) is attached. Expected h beats are pushed by the stimulus
//   side from a sequence-level model; a monitor pops and compares on every
//   h handshake.
// -----------------------------------------------------------------------------
module tb_lstm_seq_ctrl;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic [DW-1:0] c_init = '0;
  logic [DW-1:0] h_init = '0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          h_ready = 1'b0;
  logic          x_ready, h_valid, busy, done;
  logic [DW-1:0] cell_x, cell_c_in, cell_h_in, cell_c_out, cell_h_out, h_data;
  logic [LW-1:0] step_idx;

  lstm_seq_ctrl #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .LEN_W(LW), .CELL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
    .c_init(c_init), .h_init(h_init),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .cell_x(cell_x), .cell_c_in(cell_c_in), .cell_h_in(cell_h_in),
    .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
    .h_valid(h_valid), .h_data(h_data), .h_ready(h_ready),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Toy cell: two pipeline stages between its inputs and outputs.
  logic [DW-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= cell_c_in + cell_x;
    p2 <= p1;
  end
  assign cell_c_out = p2;
  assign cell_h_out = p2 >> 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [DW-1:0] h;
    logic [LW-1:0] idx;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] m_c, m_h;
  int            m_step;

  // ---------------- monitor ----------------
  int done_cnt = 0, xhs_cnt = 0, busy_cyc = 0, xr_cyc = 0, hv_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_h = '0;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      if (done)    done_cnt++;
      if (busy)    busy_cyc++;
      if (x_ready) xr_cyc++;
      if (h_valid) hv_cyc++;
      if (x_valid && x_ready) xhs_cnt++;
      if (h_valid && prev_stall) check("h_hold", h_data, prev_h);
      if (h_valid && h_ready) begin
        if (exp_q.size() == 0) check("h_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("h_data", h_data, e.h);
          check("step_idx", step_idx, e.idx);
        end
      end
      prev_stall = h_valid && !h_ready;
      prev_h     = h_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- h_ready driver ----------------
  // mode 0: always ready, 1: random, 2: low for 4 cycles of every beat.
  int hr_mode = 0;
  int hr_wait = 0;
  initial forever begin
    @(posedge clk); #1;
    case (hr_mode)
      0: h_ready = 1'b1;
      1: h_ready = 1'($urandom_range(0, 1));
      default: begin
        if (h_valid) hr_wait++;
        else         hr_wait = 0;
        h_ready = h_valid && (hr_wait > 4);
      end
    endcase
  end

  // ---------------- stimulus tasks ----------------
  task automatic do_start(input logic [DW-1:0] c0, input logic [DW-1:0] h0, input int len);
    @(posedge clk); #1;
    start = 1'b1; seq_len = LW'(len); c_init = c0; h_init = h0;
    @(posedge clk); #1;
    start = 1'b0; seq_len = LW'($urandom); c_init = DW'($urandom); h_init = DW'($urandom);
    m_c = c0; m_h = h0; m_step = 0;
  endtask

  task automatic send_x(input logic [DW-1:0] x, input int gap, input bit poke);
    int n;
    repeat (gap) begin @(posedge clk); #1; x_data = DW'($urandom); end
    x_valid = 1'b1;
    x_data  = x;
    m_c = m_c + x;
    m_h = m_c >> 1;
    exp_q.push_back('{h: m_h, idx: LW'(m_step)});
    m_step++;
    n = 0;
    @(negedge clk);
    while (!x_ready && n < 200) begin @(negedge clk); n++; end
    if (!x_ready) check("x_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    x_valid = 1'b0;
    x_data  = DW'($urandom);
    if (poke) begin
      start = 1'b1; seq_len = LW'($urandom_range(1, 255));
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    @(negedge clk);
    while (!done && n < bound) begin @(negedge clk); n++; end
    check("done_seen", done, 1'b1);
  endtask

  task automatic run_seq(input logic [DW-1:0] c0, input logic [DW-1:0] h0, input int len,
                         input int gap_lo, input int gap_hi, input bit poke, input int mode);
    int d0 = done_cnt;
    int x0 = xhs_cnt;
    logic [DW-1:0] x;
    hr_mode = mode;
    do_start(c0, h0, len);
    for (int i = 0; i < len; i++) begin
      x = (stim_q.size() > 0) ? stim_q.pop_front() : DW'($urandom);
      send_x(x, $urandom_range(gap_hi, gap_lo), poke);
    end
    wait_done(200);
    @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    check("x_handshakes", xhs_cnt - x0, len);
    check("final_c", cell_c_in, m_c);
    check("final_h", cell_h_in, m_h);
    check("sb_empty", exp_q.size(), 0);
    check("idle_after", busy, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x_ready"},  x_ready,   1'b0);
    check({tag, "_h_valid"},  h_valid,   1'b0);
    check({tag, "_busy"},     busy,      1'b0);
    check({tag, "_done"},     done,      1'b0);
    check({tag, "_step_idx"}, step_idx,  '0);
    check({tag, "_cell_x"},   cell_x,    '0);
    check({tag, "_cell_c"},   cell_c_in, '0);
    check({tag, "_cell_h"},   cell_h_in, '0);
    check({tag, "_h_data"},   h_data,    '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, d0, b0, x0, v0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed run, zero-wait handshakes
    stim_q = '{16'h0100, 16'h0200, 16'h0300};
    run_seq(16'h0000, 16'h0000, 3, 0, 0, 1'b0, 0);
    check("directed_final_c", cell_c_in, 16'h0600);
    check("directed_final_h", cell_h_in, 16'h0300);

    // Same run with 5-cycle X gaps and 4-cycle h backpressure
    stim_q = '{16'h0100, 16'h0200, 16'h0300};
    run_seq(16'h0000, 16'h0000, 3, 5, 5, 1'b0, 2);
    check("gapped_final_c", cell_c_in, 16'h0600);

    // Latency: h_valid in the cycle after edge T+3, x_ready one cycle later
    hr_mode = 0;
    d0 = done_cnt;
    do_start(16'h0010, 16'h0000, 2);
    send_x(16'h0123, 0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!h_valid && n < 20) begin n++; @(negedge clk); end
    check("h_latency", n, 3);
    @(negedge clk);
    check("x_ready_after_emit", x_ready, 1'b1);
    check("h_valid_after_emit", h_valid, 1'b0);
    @(posedge clk); #1;
    send_x(16'h0011, 0, 1'b0);
    wait_done(50);
    @(negedge clk);
    check("latency_done_count", done_cnt - d0, 1);
    check("latency_final_c", cell_c_in, m_c);

    // seq_len = 0: one busy cycle, one done, no stream activity
    hr_mode = 0;
    d0 = done_cnt; b0 = busy_cyc; x0 = xr_cyc; v0 = hv_cyc;
    do_start(16'h1234, 16'h0055, 0);
    repeat (4) @(negedge clk);
    check("len0_busy_cycles", busy_cyc - b0, 1);
    check("len0_done", done_cnt - d0, 1);
    check("len0_x_ready", xr_cyc - x0, 0);
    check("len0_h_valid", hv_cyc - v0, 0);

    // Reset mid-SETTLE of step 1 aborts the run without done
    hr_mode = 0;
    d0 = done_cnt;
    do_start(16'h0000, 16'h0000, 3);
    send_x(16'h0100, 0, 1'b0);
    send_x(16'h0200, 0, 1'b0);
    @(negedge clk);
    check("abort_in_settle", busy && !x_ready && !h_valid, 1'b1);
    #2 rst = 1'b0;
    #1 check_zero("abort");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    stim_q = '{16'h0040};
    run_seq(16'h0040, 16'h0000, 1, 0, 0, 1'b0, 0);
    check("post_abort_h", cell_h_in, 16'h0040);

    // start pulsed while busy is ignored
    run_seq(DW'($urandom), DW'($urandom), 4, 0, 2, 1'b1, 1);

    // Randomised runs
    for (int r = 0; r < 8; r++)
      run_seq(DW'($urandom), DW'($urandom), $urandom_range(1, 8), 0, 3,
              1'($urandom_range(0, 1)), $urandom_range(0, 2));

    // Full-scale sequence length
    run_seq(DW'($urandom), DW'($urandom), 255, 0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
